alu_div_sequencer: RTL and testbench
====================================

// Module: alu_div_sequencer
// PURPOSE
// Multi-cycle signed divide controller. Replaces the single-cycle combinational divide in the ALU.
// Accepts one divide request, iterates a restoring shift-subtract datapath for WIDTH cycles,
// applies sign fix-up, then returns quotient and remainder with a done pulse.
// Sits beside the ALU; the main control unit holds the pipeline on busy for divide ops.
// PARAMETERS
// WIDTH   32   operand, quotient and remainder width in bits (>=2)
// CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// clk        in   1      rising-edge clock
// reset      in   1      synchronous, active-high reset
// req_valid  in   1      divide request present
// req_ready  out  1      sequencer can accept; high only in IDLE
// dividend   in   WIDTH  signed srcA; sampled when req_valid & req_ready
// divisor    in   WIDTH  signed srcB; sampled when req_valid & req_ready
// busy       out  1      high from the accept cycle +1 through the DONE cycle (stall source)
// done       out  1      one-cycle pulse; quotient/remainder/div_zero valid this cycle
// quotient   out  WIDTH  signed quotient; held until the next accept
// remainder  out  WIDTH  signed remainder; held until the next accept
// div_zero   out  1      divisor was 0 for the completed op; held with results
// BEHAVIOUR
// - Reset values: state=IDLE, req_ready=1, busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter=0.
// - Reset mid-operation aborts the op immediately. No done pulse. Outputs take reset values next cycle.
// - Accept: req_valid & req_ready at edge N latches |dividend|, |divisor|, sign_q=sa^sb, sign_r=sa.
//   The request is ignored when req_ready=0; the requester holds valid until accepted.
// - FSM: IDLE -> CALC on accept with divisor!=0. IDLE -> DONE on accept with divisor==0.
//   CALC -> CALC while counter < WIDTH-1. CALC -> FIXUP when counter==WIDTH-1.
//   FIXUP -> DONE. DONE -> IDLE unconditionally.
// - CALC step: {rem,quo} <<= 1; if rem >= |divisor| then rem -= |divisor| and quo[0]=1.
//   Uses an unsigned WIDTH+1-bit partial remainder. Counter increments each step, 0..WIDTH-1.
// - FIXUP: quotient = sign_q ? -quo : quo; remainder = sign_r ? -rem : rem.
//   Truncating division: the quotient rounds toward zero and the remainder takes the sign of the dividend.
// - Latency: accept at edge N gives done at edge N+WIDTH+2 (34 cycles for WIDTH=32).
//   Divide-by-zero gives done at N+1.
// - Divide by zero: quotient = all ones (-1), remainder = dividend, div_zero=1.
// - Overflow (MIN / -1): quotient = MIN (wraps), remainder=0, div_zero=0. Not flagged.
// - Magnitude of MIN is taken as unsigned 2**(WIDTH-1). No loss inside the datapath.
// - busy=1 in CALC, FIXUP and DONE. req_ready = (state==IDLE).
//   Back-to-back issue is possible: a new accept is allowed on the cycle after done.
// - done is asserted only in DONE. div_zero is cleared on every accept and set only for a zero divisor.
// TESTING
// - 100 / 7 -> done 34 cycles after accept; quotient=14, remainder=2, div_zero=0.
// - -100 / 7 -> quotient=-14, remainder=-2; then 100 / -7 -> quotient=-14, remainder=2.
// - 0x80000000 / -1 -> quotient=0x80000000, remainder=0, div_zero=0.
//   Also 0x80000000 / 1 -> quotient=0x80000000.
// - 55 / 0 -> done on the next cycle; quotient=0xFFFFFFFF, remainder=55, div_zero=1.
//   The following op 9 / 3 clears div_zero and returns 3 and 0.
// - req_valid held high with 8/2 then changed to 9/3 while busy.
//   The change is ignored; the first result is 4 (rem 0); 9/3 is accepted the cycle after done.
// - reset asserted 10 cycles into 1000/3: no done pulse; next cycle all outputs 0 and req_ready=1.
//   A new 6/4 then gives quotient=1, remainder=2.

Source files
------------

// File: rtl/alu_div_sequencer.sv
// Multi-cycle signed divider: restoring shift-subtract over WIDTH steps,
// then a sign fix-up; quotient/remainder held until the next accept.
module alu_div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sign_q;
  logic             sign_r;

  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign accept    = req_valid & req_ready;

  // MIN negates to itself, which read unsigned is exactly 2**(WIDTH-1)
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;

  assign shifted = {rem, quo[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvs});
  assign diff    = shifted[WIDTH-1:0] - dvs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= a_mag;
            dvs      <= b_mag;
            sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r   <= dividend[WIDTH-1];
            div_zero <= 1'b0;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem <= ge ? diff : shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          quotient  <= sign_q ? -quo : quo;
          remainder <= sign_r ? -rem : rem;
          state     <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Bench for alu_div_sequencer: arithmetic reference model checked every
// cycle, plus directed ops with literal results and latencies.
module tb_alu_div_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         req_ready;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_chk = 0;
  int n_fail = 0;
  bit armed = 1'b0;

  bit           m_busy = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  bit           m_z = 1'b0;
  logic [W-1:0] p_q = '0;
  logic [W-1:0] p_r = '0;
  bit           p_z = 1'b0;

  alu_div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Truncating signed division done in 64 bits so MIN/-1 cannot trap
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output bit z);
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      t = sa / sb;
      q = t[W-1:0];
      t = sa % sb;
      r = t[W-1:0];
      z = 1'b0;
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_left = 0;
      m_q = '0;
      m_r = '0;
      m_z = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_q = p_q;
        m_r = p_r;
        m_z = p_z;
      end
    end else if (req_valid) begin
      model(dividend, divisor, p_q, p_r, p_z);
      m_busy = 1'b1;
      m_left = (divisor == '0) ? 1 : W + 2;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("req_ready", 64'(req_ready), 64'(!m_busy));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_busy && m_left == 1));
      if (m_busy && m_left == 1) begin
        chk("done_quotient", 64'(quotient), 64'(p_q));
        chk("done_remainder", 64'(remainder), 64'(p_r));
        chk("done_div_zero", 64'(div_zero), 64'(p_z));
      end else if (!m_busy) begin
        chk("held_quotient", 64'(quotient), 64'(m_q));
        chk("held_remainder", 64'(remainder), 64'(m_r));
        chk("held_div_zero", 64'(div_zero), 64'(m_z));
      end
    end
  end

  task automatic wait_done(inout int k);
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input bit ez, input int elat);
    int k;
    req_valid = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    wait_done(k);
    chk("lat_literal", 64'(k), 64'(elat));
    chk("q_literal", 64'(quotient), 64'(eq));
    chk("r_literal", 64'(remainder), 64'(er));
    chk("z_literal", 64'(div_zero), 64'(ez));
    @(negedge clk);
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);

    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    run_op(-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 34);
    run_op(32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 34);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
    run_op(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 34);
    run_op(32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, 1);
    run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);
    run_op(-32'sd7, -32'sd2, 32'd3, -32'sd1, 1'b0, 34);
    run_op(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 34);

    // Requester holds valid and changes operands while the op is in flight
    req_valid = 1'b1;
    dividend = 32'd8;
    divisor = 32'd2;
    @(negedge clk);
    k = 1;
    repeat (3) begin
      @(negedge clk);
      k++;
    end
    dividend = 32'd9;
    divisor = 32'd3;
    wait_done(k);
    chk("hold_lat", 64'(k), 64'd34);
    chk("hold_q", 64'(quotient), 64'd4);
    chk("hold_r", 64'(remainder), 64'd0);
    @(negedge clk);
    chk("hold_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    wait_done(k);
    chk("b2b_lat", 64'(k), 64'd34);
    chk("b2b_q", 64'(quotient), 64'd3);
    chk("b2b_r", 64'(remainder), 64'd0);
    @(negedge clk);

    // Abort an op with reset partway through
    req_valid = 1'b1;
    dividend = 32'd1000;
    divisor = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_q", 64'(quotient), 64'd0);
    chk("abort_r", 64'(remainder), 64'd0);
    chk("abort_z", 64'(div_zero), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    run_op(32'd6, 32'd4, 32'd1, 32'd2, 1'b0, 34);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
